// File: rtl/da_fir_seq.sv
// da_fir_seq: bit-serial sequencer for a distributed-arithmetic FIR.
// Holds the tap delay line and presents one bit-slice per cycle to the DA LUT/accumulator.
module da_fir_seq #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  output logic              in_ready,
  input  logic              flush,
  output logic [TAPS-1:0]   lut_addr,
  output logic              acc_en,
  output logic              acc_first,
  output logic              acc_sub,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              busy,
  output logic              out_valid
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] taps_q [TAPS];
  logic [DATA_W-1:0] taps_d [TAPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      for (int k = 0; k < TAPS; k++) begin
        taps_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      for (int k = 0; k < TAPS; k++) begin
        taps_q[k] <= taps_d[k];
      end
    end
  end

  // flush overrides every state transition, including an accept in IDLE
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    for (int k = 0; k < TAPS; k++) begin
      taps_d[k] = taps_q[k];
    end

    if (flush) begin
      state_d   = IDLE;
      bit_idx_d = '0;
      for (int k = 0; k < TAPS; k++) begin
        taps_d[k] = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              taps_d[k] = taps_q[k-1];
            end
            taps_d[0] = in_sample;
            bit_idx_d = '0;
            state_d   = COMPUTE;
          end
        end
        COMPUTE: begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = DONE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs depend only on registered state, so the LUT address is glitch-free per cycle
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    acc_en    = 1'b0;
    acc_first = 1'b0;
    acc_sub   = 1'b0;
    out_valid = 1'b0;
    lut_addr  = '0;
    bit_idx   = bit_idx_q;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      COMPUTE: begin
        busy      = 1'b1;
        acc_en    = 1'b1;
        acc_first = (bit_idx_q == '0);
        acc_sub   = (bit_idx_q == LAST_IDX);
        for (int k = 0; k < TAPS; k++) begin
          lut_addr[k] = taps_q[k][bit_idx_q];
        end
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_da_fir_seq.sv
// tb_da_fir_seq: directed self-checking bench for the DA FIR sequencer.
// Each task drives one scenario and compares outputs against hand-derived values.
module tb_da_fir_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_sample;
  logic       in_ready;
  logic       flush;
  logic [7:0] lut_addr;
  logic       acc_en;
  logic       acc_first;
  logic       acc_sub;
  logic [2:0] bit_idx;
  logic       busy;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  da_fir_seq #(.TAPS(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .in_ready  (in_ready),
    .flush     (flush),
    .lut_addr  (lut_addr),
    .acc_en    (acc_en),
    .acc_first (acc_first),
    .acc_sub   (acc_sub),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after each rising edge; inputs change at the same point
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sample = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] s);
    in_valid  = 1'b1;
    in_sample = s;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({in_ready, busy, out_valid, acc_en, acc_first, acc_sub} !== 6'b100000) begin
        bad++;
        $display("[TB] FAIL reset_ctrl cyc=%0d got=%b want=100000", c,
                 {in_ready, busy, out_valid, acc_en, acc_first, acc_sub});
      end
      total++;
      if (lut_addr !== 8'h00) begin
        bad++;
        $display("[TB] FAIL reset_lut cyc=%0d got=%h want=00", c, lut_addr);
      end
      step();
    end
    total++;
    if (bit_idx !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_idx got=%0d want=0", bit_idx);
    end
  endtask

  task automatic test_single();
    do_reset();
    send_sample(8'h01);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (lut_addr !== ((b == 0) ? 8'h01 : 8'h00)) begin
        bad++;
        $display("[TB] FAIL single_lut b=%0d got=%h want=%h", b, lut_addr,
                 (b == 0) ? 8'h01 : 8'h00);
      end
      total++;
      if ({acc_en, acc_first, acc_sub, busy, in_ready, out_valid} !==
          {1'b1, b == 0, b == 7, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL single_ctrl b=%0d got=%b want=%b", b,
                 {acc_en, acc_first, acc_sub, busy, in_ready, out_valid},
                 {1'b1, b == 0, b == 7, 1'b1, 1'b0, 1'b0});
      end
      total++;
      if (bit_idx !== 3'(b)) begin
        bad++;
        $display("[TB] FAIL single_idx got=%0d want=%0d", bit_idx, b);
      end
      step();
    end
    total++;
    if ({out_valid, busy, in_ready, acc_en, lut_addr} !== {4'b1000, 8'h00}) begin
      bad++;
      $display("[TB] FAIL single_done got=%b want=1000_00000000",
               {out_valid, busy, in_ready, acc_en, lut_addr});
    end
    step();
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL single_idle got=%b want=010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    int   i      = 0;
    int   s      = 8;
    int   pulses = 0;
    int   last   = -1;
    logic acc;
    do_reset();
    in_valid  = 1'b1;
    in_sample = 8'h01;
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (out_valid === 1'b1) begin
        if (pulses > 0) begin
          total++;
          if (cyc - last != 10) begin
            bad++;
            $display("[TB] FAIL b2b_spacing got=%0d want=10", cyc - last);
          end
        end
        last = cyc;
        pulses++;
      end
      if (s < 8) begin
        total++;
        if (lut_addr !== (8'h80 >> s)) begin
          bad++;
          $display("[TB] FAIL b2b_lut slice=%0d got=%h want=%h", s, lut_addr, 8'h80 >> s);
        end
        s++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        i++;
        if (i < 8) begin
          in_sample = 8'h01 << i;
        end else begin
          in_valid = 1'b0;
          s = 0;
        end
      end
    end
    total++;
    if (pulses != 8) begin
      bad++;
      $display("[TB] FAIL b2b_pulses got=%0d want=8", pulses);
    end
  endtask

  task automatic test_negative();
    do_reset();
    send_sample(8'h80);
    for (int b = 0; b < 8; b++) begin
      total++;
      if ({lut_addr, acc_sub} !== ((b == 7) ? 9'h003 : 9'h000)) begin
        bad++;
        $display("[TB] FAIL neg_slice b=%0d got=%h/%b want=%h/%b", b, lut_addr, acc_sub,
                 (b == 7) ? 8'h01 : 8'h00, b == 7);
      end
      step();
    end
    step();
  endtask

  task automatic test_hold();
    logic [7:0] a = 8'h33;
    logic [7:0] c = 8'h5A;
    do_reset();
    in_valid  = 1'b1;
    in_sample = a;
    step();
    in_sample = c;
    for (int b = 0; b < 8; b++) begin
      total++;
      if ({in_ready, lut_addr} !== {1'b0, 7'b0, a[b]}) begin
        bad++;
        $display("[TB] FAIL hold_first b=%0d got=%b/%h want=0/%h", b, in_ready, lut_addr,
                 {7'b0, a[b]});
      end
      step();
    end
    total++;
    if ({out_valid, in_ready} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL hold_done got=%b want=10", {out_valid, in_ready});
    end
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_ready got=%b want=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      total++;
      if (lut_addr !== {6'b0, a[b], c[b]}) begin
        bad++;
        $display("[TB] FAIL hold_second b=%0d got=%h want=%h", b, lut_addr,
                 {6'b0, a[b], c[b]});
      end
      step();
    end
    step();
    for (int q = 0; q < 3; q++) begin
      total++;
      if ({busy, in_ready} !== 2'b01) begin
        bad++;
        $display("[TB] FAIL hold_quiet q=%0d got=%b want=01", q, {busy, in_ready});
      end
      step();
    end
  endtask

  task automatic test_abort(input bit use_reset);
    do_reset();
    send_sample(8'h55);
    repeat (9) step();
    send_sample(8'hAA);
    repeat (3) step();
    total++;
    if (bit_idx !== 3'd3) begin
      bad++;
      $display("[TB] FAIL abort_pre_idx rst=%0d got=%0d want=3", use_reset, bit_idx);
    end
    if (use_reset) begin
      reset = 1'b1;
    end else begin
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_sample = 8'h77;
    end
    step();
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if ({in_ready, busy, out_valid, acc_en, acc_first, acc_sub, lut_addr, bit_idx} !==
        {6'b100000, 8'h00, 3'd0}) begin
      bad++;
      $display("[TB] FAIL abort_state rst=%0d got=%b want=100000_00000000_000", use_reset,
               {in_ready, busy, out_valid, acc_en, acc_first, acc_sub, lut_addr, bit_idx});
    end
    if (!use_reset) begin
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_sample = 8'h77;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      total++;
      if ({in_ready, busy} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL flush_no_accept got=%b want=10", {in_ready, busy});
      end
    end
    for (int q = 0; q < 10; q++) begin
      total++;
      if ({out_valid, busy} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL abort_quiet rst=%0d q=%0d got=%b want=00", use_reset, q,
                 {out_valid, busy});
      end
      step();
    end
    send_sample(8'hFF);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (lut_addr !== 8'h01) begin
        bad++;
        $display("[TB] FAIL abort_cleared rst=%0d b=%0d got=%h want=01", use_reset, b,
                 lut_addr);
      end
      step();
    end
    step();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sample = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_negative();
    test_hold();
    test_abort(1'b1);
    test_abort(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
